// File: rtl/ibex_id_sequencer_pkg.sv
// ID-stage sequencing types shared by the ID sequencer and its assertions.
package ibex_pkg;

  // ID-stage FSM: an instruction is either in its first cycle or continuing.
  typedef enum logic {
    FIRST_CYCLE = 1'b0,
    MULTI_CYCLE = 1'b1
  } id_fsm_e;

  // Reason the instruction currently in ID needs another cycle.
  typedef enum logic [2:0] {
    STALL_NONE    = 3'd0,
    STALL_MEM     = 3'd1,
    STALL_MULTDIV = 3'd2,
    STALL_JUMP    = 3'd3,
    STALL_BRANCH  = 3'd4,
    STALL_ALU     = 3'd5
  } id_stall_e;

endpackage

// File: rtl/ibex_id_sequencer.sv
// ID/EX multi-cycle instruction sequencer and ID-stage FSM.
// Optional feature: define IBEX_ID_SEQ_STALL_CNT_EN to build a 16-bit
// saturating stall-cycle counter; otherwise perf_stall_cnt_o is tied to 0.
module ibex_id_sequencer
  import ibex_pkg::*;
#(
  parameter bit BranchTargetALU = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic        flush_id_i,
  input  logic        halt_id_i,
  input  logic        illegal_insn_i,
  input  logic        jump_in_dec_i,
  input  logic        branch_in_dec_i,
  input  logic        data_req_dec_i,
  input  logic        mult_en_dec_i,
  input  logic        div_en_dec_i,
  input  logic        alu_multicycle_dec_i,
  input  logic        branch_taken_i,
  input  logic        multdiv_valid_i,
  input  logic        lsu_resp_valid_i,
  output logic        instr_first_cycle_o,
  output logic        stall_id_o,
  output logic        instr_done_o,
  output logic        lsu_req_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        jump_set_o,
  output logic        branch_set_o,
  output logic [15:0] perf_stall_cnt_o
);

  id_fsm_e   id_fsm_q, id_fsm_d;
  id_stall_e stall_reason;
  logic      first_cycle;
  logic      seq_go;
  logic      done;

  assign first_cycle = (id_fsm_q == FIRST_CYCLE);

  // Halt only blocks starting an instruction; once in MULTI_CYCLE the
  // instruction runs to completion so its result is never lost.
  assign seq_go = instr_valid_i & ~flush_id_i & ~illegal_insn_i &
                  (~halt_id_i | ~first_cycle);

  // ID FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fsm_q <= FIRST_CYCLE;
    end else begin
      id_fsm_q <= id_fsm_d;
    end
  end

  // Next state, completion, per-class strobes and stall reason.
  always_comb begin
    id_fsm_d     = id_fsm_q;
    done         = 1'b0;
    lsu_req_o    = 1'b0;
    mult_en_o    = 1'b0;
    div_en_o     = 1'b0;
    jump_set_o   = 1'b0;
    branch_set_o = 1'b0;
    stall_reason = STALL_NONE;

    if (flush_id_i) begin
      id_fsm_d = FIRST_CYCLE;
    end else if (seq_go) begin
      if (data_req_dec_i) begin
        lsu_req_o = first_cycle;
        if (lsu_resp_valid_i) done = 1'b1;
        else                  stall_reason = STALL_MEM;
      end else if (mult_en_dec_i || div_en_dec_i) begin
        mult_en_o = mult_en_dec_i;
        div_en_o  = div_en_dec_i;
        if (multdiv_valid_i) done = 1'b1;
        else                 stall_reason = STALL_MULTDIV;
      end else if (jump_in_dec_i) begin
        jump_set_o = first_cycle;
        if (BranchTargetALU || !first_cycle) done = 1'b1;
        else                                 stall_reason = STALL_JUMP;
      end else if (branch_in_dec_i) begin
        // Reaching MULTI_CYCLE on a branch implies it was taken in cycle one.
        if (!first_cycle) begin
          branch_set_o = 1'b1;
          done         = 1'b1;
        end else if (!branch_taken_i) begin
          done = 1'b1;
        end else if (BranchTargetALU) begin
          branch_set_o = 1'b1;
          done         = 1'b1;
        end else begin
          stall_reason = STALL_BRANCH;
        end
      end else if (alu_multicycle_dec_i) begin
        if (!first_cycle) done = 1'b1;
        else              stall_reason = STALL_ALU;
      end else begin
        done = 1'b1;
      end
      id_fsm_d = done ? FIRST_CYCLE : MULTI_CYCLE;
    end
  end

  assign instr_first_cycle_o = first_cycle;
  assign instr_done_o        = done;
  assign stall_id_o          = (stall_reason != STALL_NONE);

`ifdef IBEX_ID_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (stall_id_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

  a_class_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({jump_in_dec_i, branch_in_dec_i, data_req_dec_i,
              mult_en_dec_i, div_en_dec_i, alu_multicycle_dec_i}));

  a_state_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(id_fsm_q));

  a_set_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(jump_set_o && branch_set_o));

  a_stall_reason: assert property (@(posedge clk_i) disable iff (!rst_ni)
    stall_id_o == (instr_valid_i & ~instr_done_o & ~flush_id_i & seq_go));

  a_done_not_flush: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_done_o && flush_id_i));

endmodule

// File: doc/ibex_id_sequencer.md
# ibex_id_sequencer

Sequences every multi-cycle instruction through the ID/EX stage and owns the ID-stage FSM. It takes the decoder's per-instruction class flags and the completion strobes from the ALU, multiplier/divider and LSU, then produces:
- the `instr_first_cycle` indication back to the decoder,
- stall and done strobes to the controller and pipeline register,
- one-shot enables for the LSU and multdiv unit,
- jump/branch set strobes for the IF stage.

## Interface
Parameters:
- `BranchTargetALU`, default 0: 1 means a separate branch-target adder exists, so taken branches and jumps complete in one cycle.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `instr_valid_i` in 1: valid instruction is present in ID.
- `flush_id_i` in 1: controller kills the instruction in ID.
- `halt_id_i` in 1: controller holds ID; no new sequencing starts.
- `illegal_insn_i` in 1: decoder flagged the instruction illegal.
- `jump_in_dec_i`, `branch_in_dec_i`, `data_req_dec_i`, `mult_en_dec_i`, `div_en_dec_i`, `alu_multicycle_dec_i` in 1 each: instruction class flags from the decoder. At most one is set.
- `branch_taken_i` in 1: ALU branch comparison result.
- `multdiv_valid_i` in 1: multdiv result ready.
- `lsu_resp_valid_i` in 1: LSU response (data or error) returned.
- `instr_first_cycle_o` out 1: ID is in its first cycle for this instruction.
- `stall_id_o` out 1: instruction needs more cycles.
- `instr_done_o` out 1: instruction retires this cycle.
- `lsu_req_o` out 1: LSU request strobe.
- `mult_en_o`, `div_en_o` out 1: multdiv enables, gated by illegal/flush.
- `jump_set_o`, `branch_set_o` out 1: PC redirect strobes to IF.
- `perf_stall_cnt_o` out 16: saturating count of stall cycles.

## Operation
- FSM states (`id_fsm_e`): `FIRST_CYCLE`, `MULTI_CYCLE`. Reset state is `FIRST_CYCLE`.
- A cycle is *active* when `instr_valid_i & ~halt_id_i & ~flush_id_i & ~illegal_insn_i`. All class behaviour below applies only in active cycles.
- In `FIRST_CYCLE`, an active cycle with no class flag sets gives `instr_done_o`=1.
- `data_req_dec_i`:
  - `lsu_req_o`=1 in the first cycle only.
  - Go to `MULTI_CYCLE`, stall until `lsu_resp_valid_i`; done in that cycle.
  - A response already present in the first cycle completes in one cycle.
- `mult_en_dec_i`/`div_en_dec_i`:
  - The matching enable is high in every cycle of the instruction.
  - Stall until `multdiv_valid_i`; done in that cycle.
- `jump_in_dec_i`:
  - `jump_set_o`=1 in the first cycle.
  - With `BranchTargetALU`=1: done in one cycle.
  - Otherwise: one `MULTI_CYCLE` cycle (link write), then done.
- `branch_in_dec_i`:
  - Not taken: done in one cycle.
  - Taken, `BranchTargetALU`=1: `branch_set_o`=1 and done in the first cycle.
  - Taken, `BranchTargetALU`=0: stall the first cycle, then `branch_set_o`=1 and done in the `MULTI_CYCLE` cycle. `branch_taken_i` is sampled in the first cycle only.
- `alu_multicycle_dec_i`: exactly two cycles; done in the second.
- `instr_first_cycle_o` = (state == `FIRST_CYCLE`).
- `stall_id_o` = `instr_valid_i & ~instr_done_o & ~flush_id_i` while sequencing.
- Illegal instruction:
  - all strobes and enables are 0; no state change;
  - `instr_done_o`=0, because the controller raises the exception.
- `flush_id_i` has priority over everything:
  - all strobes are 0;
  - next state is `FIRST_CYCLE`;
  - an outstanding multdiv is abandoned, since enables drop.
- `halt_id_i` in `FIRST_CYCLE`: no strobes, stay.
- `halt_id_i` in `MULTI_CYCLE`: ignored; the instruction continues so completion is never lost.

## Timing
- The state register is the only sequential element besides the counter. All outputs are combinational from state and inputs; no output-to-input combinational loop.
- Reset values (with `instr_valid_i`=0): `instr_first_cycle_o`=1; every other output 0; `perf_stall_cnt_o`=0.
- Minimum latency is 1 cycle. Jumps and taken branches without BTALU take exactly 2 cycles. LSU and multdiv latency is unbounded and equals the response latency.
- Reset asserted mid-instruction returns the FSM immediately to `FIRST_CYCLE` with no done.
- `instr_done_o` and `flush_id_i` never coincide.

## Configuration
- `IBEX_ID_SEQ_STALL_CNT_EN` defined: 16-bit counter increments each cycle `stall_id_o`=1 and saturates at 0xFFFF. It is cleared only by reset.
- Macro not defined: no counter flops; `perf_stall_cnt_o` is tied to 0.

## Structure
- `ibex_pkg` holds `id_fsm_e` and the stall-reason enum `id_stall_e` (`STALL_NONE`, `STALL_MEM`, `STALL_MULTDIV`, `STALL_JUMP`, `STALL_BRANCH`, `STALL_ALU`). The enum is used internally and by assertions.
- Single flat module; no sub-module.
- Assertions:
  - class flags are one-hot-or-zero;
  - state is known after reset;
  - `jump_set_o` and `branch_set_o` are mutually exclusive.

## Test plan
- Load, `lsu_resp_valid_i` 3 cycles after the request -> `lsu_req_o` one cycle; stall 3 cycles; `instr_done_o` on cycle 4.
- Taken branch, `BranchTargetALU`=0 -> cycle 1 stall; cycle 2 `branch_set_o`=1 and done. With `BranchTargetALU`=1 -> both in cycle 1.
- DIV with `multdiv_valid_i` after 37 cycles, flush at cycle 10 -> `div_en_o` drops in cycle 10, FSM is `FIRST_CYCLE` in cycle 11, no done.
- Illegal JAL -> `jump_set_o`=0, `instr_done_o`=0, `instr_first_cycle_o` stays 1.
- `halt_id_i` during the second cycle of a JAL (`BranchTargetALU`=0) -> done is still produced in that cycle.
- With the macro defined, 70000 stall cycles -> `perf_stall_cnt_o`=0xFFFF. With the macro undefined -> 0.
